// File: rtl/axi4s_fcs_strip_if.sv
// axi4s_fcs_strip_if: AXI4-Stream bundle whose tuser is {error, bytecount}.
// Ports: tdata/tuser/tlast/tvalid flow source->sink, tready flows sink->source.
// master = source side, slave = sink side.
interface axi4s_fcs_strip_if #(
  parameter int DATA_WIDTH = 64,
  parameter int UWIDTH = $clog2(DATA_WIDTH/8) + 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [UWIDTH-1:0] tuser;
  logic tlast, tvalid, tready;
  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axi4s_fcs_strip.sv
// axi4s_fcs_strip: removes the trailing TRIM_BYTES bytes (FCS) of every AXI4-Stream packet.
// Ports: clk, rst_n (async active-low); s = input stream (slave), m = output stream (master);
// runt_drop pulses for one cycle when a whole packet is too short to survive the trim.
module axi4s_fcs_strip #(
  parameter int DATA_WIDTH = 64,
  parameter int TRIM_BYTES = 4
) (
  input logic clk,
  input logic rst_n,
  axi4s_fcs_strip_if.slave s,
  axi4s_fcs_strip_if.master m,
  output logic runt_drop
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int CW = $clog2(BPW);
  localparam logic [CW-1:0] TRIM_C = CW'(TRIM_BYTES);
  typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_LAST} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] h_data;
  logic [CW-1:0] h_cnt, cnt;
  logic h_err, sticky, err_acc, xfer_in, runt;
  // A bytecount of 0 means a full word, which always outlives the trim.
  assign runt = s.tlast && s.tuser[CW-1:0] != '0 && s.tuser[CW-1:0] <= TRIM_C;
  // n-TRIM (kept last beat) and BPW-TRIM+n (absorbed last beat) agree modulo BPW.
  assign cnt = s.tuser[CW-1:0] - TRIM_C;
  assign err_acc = sticky | s.tuser[CW];
  assign xfer_in = s.tvalid && s.tready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_EMPTY;
    else state <= state_nxt;
  // Once the held beat leaves, every state treats an accepted input beat identically.
  always_comb begin
    state_nxt = xfer_in ? (!s.tlast ? ST_HOLD : runt ? ST_EMPTY : ST_LAST)
              : (state == ST_LAST && m.tready) ? ST_EMPTY : state;
  end
  always_comb begin
    s.tready = state == ST_EMPTY ? 1'b1 : m.tready;
    m.tvalid = state == ST_HOLD ? s.tvalid : state == ST_LAST;
    m.tlast = state == ST_HOLD ? runt : state == ST_LAST;
    m.tdata = h_data;
    m.tuser = state == ST_HOLD ? {err_acc, runt ? cnt : {CW{1'b0}}}
            : state == ST_LAST ? {h_err, h_cnt} : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_data <= '0;
      h_cnt <= '0;
      h_err <= 1'b0;
      sticky <= 1'b0;
      runt_drop <= 1'b0;
    end else begin
      // A runt arriving in ST_HOLD is absorbed into the held beat, not dropped.
      runt_drop <= xfer_in && runt && state != ST_HOLD;
      if (xfer_in) begin
        sticky <= s.tlast ? 1'b0 : err_acc;
        if (!runt) begin
          h_data <= s.tdata;
          h_cnt <= cnt;
          h_err <= err_acc;
        end
      end
    end
endmodule
